alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered successor to the model machine's 8-bit combinational ALU.
//  Keeps the m/s opcode map of the existing ALU, adds ADC, bit-serial shifts and an optional iterative multiply.
//  Result and flags sit in output registers; a start/busy/done handshake lets the controller sequence multi-cycle ops.
//  Sits between the register file/bus and the controller in the model-machine datapath.
// PARAMETERS
//  WIDTH  8  operand/result width; power of 2, >= 4
//  SHW    $clog2(WIDTH)  shift-count width (derived, not overridden)
// PORTS
//  clk    in   1      clock, rising edge
//  rst    in   1      reset, asynchronous, active-high
//  start  in   1      op request; sampled only when busy=0
//  m      in   1      mode: 1 = arithmetic/logic, 0 = transfer
//  s      in   4      opcode select
//  a      in   WIDTH  operand A (shift count in a[SHW-1:0] for shifts)
//  b      in   WIDTH  operand B
//  t      out  WIDTH  registered result
//  cf     out  1      registered carry/borrow flag
//  zf     out  1      registered zero flag
//  busy   out  1      high while a multi-cycle op runs
//  done   out  1      one-cycle pulse; t/cf/zf valid from this cycle
// BEHAVIOUR
//  Reset (async, any time incl. mid-op): state=IDLE, t=0, cf=0, zf=0, busy=0, done=0; op in flight is discarded.
//  On start while IDLE: latch m, s, a, b, old cf. start while busy=1 is ignored (no queueing).
//  Opcodes (m,s):
//    1,1001 ADD {cf,t}=a+b             1,0110 SUB {cf,t}=b-a (cf=borrow)
//    1,0001 ADC {cf,t}=a+b+cf_old      1,1011 AND t=a&b      1,0101 NOT t=~b
//    1,1101 SHL t=b<<n, n=a[SHW-1:0]   1,1110 SHR t=b>>n (logical)
//    1,0011 MUL (optional, see CONFIGURATION)
//    0,1010 t=b    0,1100 / 0,0100 t=a
//    any other code: t=0, cf=0, zf=0 (still completes with done).
//  Flags: ADD/SUB/ADC: cf from WIDTH+1-bit result, zf=(t==0).
//    SHL/SHR: cf = last bit shifted out (0 if n=0), zf=(t==0).
//    AND/NOT/transfer/unknown: cf=0, zf=0 (unchanged from 8-bit ALU).
//  FSM: IDLE -> (single-cycle op) DONE pulse; IDLE -> RUN (shift n>0, MUL) -> done pulse -> IDLE.
//    Single-cycle ops and shifts with n=0: t/cf/zf/done update at edge 1 after start edge; busy stays 0.
//    Shift n>0: one bit per cycle, busy=1 for n cycles, done at edge n+1; cf/zf/t written only at completion.
//    MUL: busy=1 for WIDTH cycles, done at edge WIDTH+1.
//  t/cf/zf hold their values between ops; done never overlaps busy; new start accepted the cycle done is high.
//  Arithmetic wraps modulo 2^WIDTH; no overflow flag.
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined: (1,0011) = unsigned shift-add multiply, 2*WIDTH product; t=low half,
//    cf=|high half (product did not fit), zf=(full product==0).
//  ALU_SEQ_MUL_EN undefined: (1,0011) decodes as unknown (t=0, cf=0, zf=0, 1-cycle); no multiplier logic.
// TESTING (WIDTH=8)
//  ADD a=8'hFF,b=8'h01 -> done @+1, t=00, cf=1, zf=1; then ADC a=00,b=00 -> t=01, cf=0, zf=0.
//  SUB a=05,b=03 -> t=FE, cf=1, zf=0; SUB a=07,b=07 -> t=00, cf=0, zf=1; AND/NOT/transfer -> cf=zf=0.
//  SHL b=8'h81, a=3 -> busy 3 cycles, done @+4, t=08, cf=0; SHR b=01, a=1 -> t=00, cf=1, zf=1; a=0 -> 1-cycle, t=b.
//  MUL (EN) a=10,b=10 -> busy 8 cycles, done @+9, t=00, cf=1, zf=0; without EN -> t=00, cf=0, done @+1.
//  start pulsed during SHL busy -> ignored, result unchanged; start on done cycle -> accepted.
//  rst asserted mid-SHL (async, between edges) -> t=0, cf=zf=0, busy=0, done never pulses.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered, start/busy/done successor to the model-machine 8-bit ALU.
// Define ALU_SEQ_MUL_EN to build the iterative unsigned multiplier on opcode (m=1, s=0011).
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             m,
    input  logic [3:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] t,
    output logic             cf,
    output logic             zf,
    output logic             busy,
    output logic             done
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = SHW + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};
`ifdef ALU_SEQ_MUL_EN
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(WIDTH);
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE   = 4'd0,
        OP_ADD    = 4'd1,
        OP_SUB    = 4'd2,
        OP_ADC    = 4'd3,
        OP_AND    = 4'd4,
        OP_NOT    = 4'd5,
        OP_SHL    = 4'd6,
        OP_SHR    = 4'd7,
        OP_MUL    = 4'd8,
        OP_PASS_A = 4'd9,
        OP_PASS_B = 4'd10
    } op_e;

    // Opcode map inherited from the combinational ALU; unlisted codes fall to OP_NONE.
    function automatic op_e decode_op(input logic m_v, input logic [3:0] s_v);
        op_e op_v;
        case ({m_v, s_v})
            5'b1_1001: op_v = OP_ADD;
            5'b1_0110: op_v = OP_SUB;
            5'b1_0001: op_v = OP_ADC;
            5'b1_1011: op_v = OP_AND;
            5'b1_0101: op_v = OP_NOT;
            5'b1_1101: op_v = OP_SHL;
            5'b1_1110: op_v = OP_SHR;
`ifdef ALU_SEQ_MUL_EN
            5'b1_0011: op_v = OP_MUL;
`endif
            5'b0_1010: op_v = OP_PASS_B;
            5'b0_1100: op_v = OP_PASS_A;
            5'b0_0100: op_v = OP_PASS_A;
            default:   op_v = OP_NONE;
        endcase
        return op_v;
    endfunction

    state_e           state_r;
    op_e              op_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] t_r;
    logic             cf_r;
    logic             zf_r;
    logic             busy_r;
    logic             done_r;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH:0]   mul_sum_s;
`endif

    op_e              op_s;
    logic [SHW-1:0]   n_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   adc_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] res_t_s;
    logic             res_cf_s;
    logic             res_zf_s;
    logic             multi_s;

    logic [WIDTH-1:0] step_work_s;
    logic             fin_cf_s;
    logic             fin_zf_s;

    // Decode the request and compute the single-cycle result straight from the inputs.
    always_comb begin
        op_s     = decode_op(m, s);
        n_s      = a[SHW-1:0];
        add_s    = {1'b0, a} + {1'b0, b};
        adc_s    = add_s + {{WIDTH{1'b0}}, cf_r};
        sub_s    = {1'b0, b} - {1'b0, a};
        res_t_s  = {WIDTH{1'b0}};
        res_cf_s = 1'b0;
        res_zf_s = 1'b0;
        multi_s  = 1'b0;
        case (op_s)
            OP_ADD: begin
                res_t_s  = add_s[WIDTH-1:0];
                res_cf_s = add_s[WIDTH];
                res_zf_s = (add_s[WIDTH-1:0] == {WIDTH{1'b0}});
            end
            OP_ADC: begin
                res_t_s  = adc_s[WIDTH-1:0];
                res_cf_s = adc_s[WIDTH];
                res_zf_s = (adc_s[WIDTH-1:0] == {WIDTH{1'b0}});
            end
            OP_SUB: begin
                res_t_s  = sub_s[WIDTH-1:0];
                res_cf_s = sub_s[WIDTH];
                res_zf_s = (sub_s[WIDTH-1:0] == {WIDTH{1'b0}});
            end
            OP_AND:    res_t_s = a & b;
            OP_NOT:    res_t_s = ~b;
            OP_PASS_A: res_t_s = a;
            OP_PASS_B: res_t_s = b;
            OP_SHL, OP_SHR: begin
                // A zero count finishes at once: nothing shifted out, so cf stays 0.
                if (n_s == {SHW{1'b0}}) begin
                    res_t_s  = b;
                    res_zf_s = (b == {WIDTH{1'b0}});
                end else begin
                    multi_s  = 1'b1;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:    multi_s = 1'b1;
`endif
            default: begin
                res_t_s  = {WIDTH{1'b0}};
                res_cf_s = 1'b0;
                res_zf_s = 1'b0;
            end
        endcase
    end

    // One iteration of the running multi-cycle op, plus the flags if it is the last one.
    always_comb begin
        step_work_s = work_r;
        fin_cf_s    = 1'b0;
        fin_zf_s    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mul_sum_s   = {1'b0, hi_r} + (work_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
`endif
        case (op_r)
            OP_SHL: begin
                step_work_s = {work_r[WIDTH-2:0], 1'b0};
                fin_cf_s    = work_r[WIDTH-1];
                fin_zf_s    = (step_work_s == {WIDTH{1'b0}});
            end
            OP_SHR: begin
                step_work_s = {1'b0, work_r[WIDTH-1:1]};
                fin_cf_s    = work_r[0];
                fin_zf_s    = (step_work_s == {WIDTH{1'b0}});
            end
`ifdef ALU_SEQ_MUL_EN
            // Shift-add: {hi_r, work_r} holds partial product over the remaining multiplier bits.
            OP_MUL: begin
                step_work_s = {mul_sum_s[0], work_r[WIDTH-1:1]};
                fin_cf_s    = |mul_sum_s[WIDTH:1];
                fin_zf_s    = (mul_sum_s[WIDTH:1] == {WIDTH{1'b0}}) &&
                              (step_work_s == {WIDTH{1'b0}});
            end
`endif
            default: begin
                step_work_s = work_r;
                fin_cf_s    = 1'b0;
                fin_zf_s    = 1'b0;
            end
        endcase
    end

    // Control FSM with registered result, flags and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= OP_NONE;
            cnt_r   <= {CNT_W{1'b0}};
            work_r  <= {WIDTH{1'b0}};
            t_r     <= {WIDTH{1'b0}};
            cf_r    <= 1'b0;
            zf_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi_r    <= {WIDTH{1'b0}};
            mcand_r <= {WIDTH{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (multi_s) begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                            op_r    <= op_s;
                            work_r  <= b;
`ifdef ALU_SEQ_MUL_EN
                            cnt_r   <= (op_s == OP_MUL) ? CNT_MUL : {1'b0, n_s};
                            hi_r    <= {WIDTH{1'b0}};
                            mcand_r <= a;
`else
                            cnt_r   <= {1'b0, n_s};
`endif
                        end else begin
                            t_r    <= res_t_s;
                            cf_r   <= res_cf_s;
                            zf_r   <= res_zf_s;
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    work_r <= step_work_s;
                    cnt_r  <= cnt_r - CNT_ONE;
`ifdef ALU_SEQ_MUL_EN
                    hi_r   <= mul_sum_s[WIDTH:1];
`endif
                    // Outputs are only touched on the final iteration.
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        t_r     <= step_work_s;
                        cf_r    <= fin_cf_s;
                        zf_r    <= fin_zf_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign t    = t_r;
    assign cf   = cf_r;
    assign zf   = zf_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): stimulus pushes expected results, a negedge monitor checks every done.
// Expectations for opcode (1,0011) follow ALU_SEQ_MUL_EN.
`timescale 1ns/1ps
module tb_alu_seq;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       m     = 1'b0;
    logic [3:0] s     = 4'h0;
    logic [7:0] a     = 8'h00;
    logic [7:0] b     = 8'h00;
    logic [7:0] t;
    logic       cf;
    logic       zf;
    logic       busy;
    logic       done;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string      nm;
        logic [7:0] et;
        logic       ecf;
        logic       ezf;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .m     (m),
        .s     (s),
        .a     (a),
        .b     (b),
        .t     (t),
        .cf    (cf),
        .zf    (zf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.nm, "_t"},    32'(t),    32'(mon_e.et));
                check({mon_e.nm, "_cf"},   32'(cf),   32'(mon_e.ecf));
                check({mon_e.nm, "_zf"},   32'(zf),   32'(mon_e.ezf));
                check({mon_e.nm, "_lat"},  32'(cyc),  32'(mon_e.done_cyc));
                check({mon_e.nm, "_busy"}, 32'(busy), 32'd0);
            end
        end
    end

    task automatic drive(input logic mm, input logic [3:0] ss, input logic [7:0] aa, input logic [7:0] bb);
        m = mm; s = ss; a = aa; b = bb; start = 1'b1;
    endtask

    task automatic expect_op(input string nm, input logic [7:0] et, input logic ecf, input logic ezf, input int lat);
        exp_t e;
        e.nm = nm; e.et = et; e.ecf = ecf; e.ezf = ezf;
        e.done_cyc = cyc + lat;
        exp_q.push_back(e);
    endtask

    task automatic issue(input string nm, input logic mm, input logic [3:0] ss, input logic [7:0] aa,
                         input logic [7:0] bb, input logic [7:0] et, input logic ecf, input logic ezf,
                         input int lat);
        @(negedge clk);
        drive(mm, ss, aa, bb);
        expect_op(nm, et, ecf, ezf, lat);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL timeout: %0d result(s) still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_op(input string nm, input logic mm, input logic [3:0] ss, input logic [7:0] aa,
                          input logic [7:0] bb, input logic [7:0] et, input logic ecf, input logic ezf,
                          input int lat);
        issue(nm, mm, ss, aa, bb, et, ecf, ezf, lat);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_t",    32'(t),    32'd0);
        check("rst_cf",   32'(cf),   32'd0);
        check("rst_zf",   32'(zf),   32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        //      name          m     s        a      b      t      cf    zf    lat
        run_op("add_ff_01",  1'b1, 4'b1001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1);
        run_op("adc_00_00",  1'b1, 4'b0001, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1);
        run_op("sub_05_03",  1'b1, 4'b0110, 8'h05, 8'h03, 8'hFE, 1'b1, 1'b0, 1);
        run_op("adc_borrow", 1'b1, 4'b0001, 8'h01, 8'h02, 8'h04, 1'b0, 1'b0, 1);
        run_op("sub_07_07",  1'b1, 4'b0110, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1, 1);
        run_op("and",        1'b1, 4'b1011, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1);
        run_op("not",        1'b1, 4'b0101, 8'hAA, 8'h0F, 8'hF0, 1'b0, 1'b0, 1);
        run_op("mov_b",      1'b0, 4'b1010, 8'h12, 8'h34, 8'h34, 1'b0, 1'b0, 1);
        run_op("mov_a_c",    1'b0, 4'b1100, 8'h12, 8'h34, 8'h12, 1'b0, 1'b0, 1);
        run_op("mov_a_4",    1'b0, 4'b0100, 8'h56, 8'h34, 8'h56, 1'b0, 1'b0, 1);
        run_op("add_80_80",  1'b1, 4'b1001, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1);
        run_op("unknown",    1'b1, 4'b0000, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1);
        run_op("shl_81_3",   1'b1, 4'b1101, 8'h03, 8'h81, 8'h08, 1'b0, 1'b0, 4);
        run_op("shr_01_1",   1'b1, 4'b1110, 8'h01, 8'h01, 8'h00, 1'b1, 1'b1, 2);
        run_op("shl_n0",     1'b1, 4'b1101, 8'h08, 8'h5A, 8'h5A, 1'b0, 1'b0, 1);
        run_op("shr_c0_7",   1'b1, 4'b1110, 8'h07, 8'hC0, 8'h01, 1'b1, 1'b0, 8);
        run_op("shl_ff_7",   1'b1, 4'b1101, 8'h07, 8'hFF, 8'h80, 1'b1, 1'b0, 8);
        run_op("add_pre_mul",1'b1, 4'b1001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
        run_op("mul_10_10",  1'b1, 4'b0011, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 9);
        run_op("mul_0d_0b",  1'b1, 4'b0011, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 9);
        run_op("mul_zero",   1'b1, 4'b0011, 8'h00, 8'h37, 8'h00, 1'b0, 1'b1, 9);
`else
        run_op("mul_off",    1'b1, 4'b0011, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 1);
`endif

        // A start while busy must be dropped without disturbing the running shift.
        issue("shl_busy", 1'b1, 4'b1101, 8'h03, 8'h81, 8'h08, 1'b0, 1'b0, 4);
        check("busy_high", 32'(busy), 32'd1);
        drive(1'b1, 4'b1001, 8'hFF, 8'h01);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        check("ignored_t",  32'(t),  32'h08);
        check("ignored_cf", 32'(cf), 32'd0);
        check("ignored_zf", 32'(zf), 32'd0);

        // A start presented in the done cycle must be accepted.
        issue("shr_pre", 1'b1, 4'b1110, 8'h01, 8'h01, 8'h00, 1'b1, 1'b1, 2);
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        drive(1'b1, 4'b1001, 8'hFF, 8'h02);
        expect_op("add_on_done", 8'h01, 1'b1, 1'b0, 1);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of a shift discards it.
        @(negedge clk);
        drive(1'b1, 4'b1101, 8'h05, 8'hFF);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_t",    32'(t),    32'd0);
        check("arst_cf",   32'(cf),   32'd0);
        check("arst_zf",   32'(zf),   32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_t",    32'(t),    32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        run_op("add_after_rst", 1'b1, 4'b1001, 8'h21, 8'h12, 8'h33, 1'b0, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
